// File: rtl/tdm_pkg.sv
// Shared TDM framing constants and types for the receive and transmit ends.
package tdm_pkg;

  localparam int unsigned SLOTS  = 32;
  localparam int unsigned SLOT_W = 5;
  localparam int unsigned BITS   = 8;
  localparam int unsigned BIT_W  = 3;

  localparam logic [BITS-1:0] DEFAULT_FAS = 8'h1B;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PRESYNC = 2'd1,
    LOCK    = 2'd2
  } sync_state_t;

  // One deserialized payload slot as handed downstream.
  typedef struct packed {
    logic [BITS-1:0]   data;
    logic [SLOT_W-1:0] slot;
    logic              perr;
  } slot_rec_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// Loadable bit/slot position counter with end-of-slot and end-of-frame flags.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              reset_l,
  input  logic              i_load,
  input  logic              i_en,
  output logic [SLOT_W-1:0] o_slotcnt,
  output logic              o_eos_c,
  output logic              o_eof_c
);

  logic [BIT_W-1:0]  r_bitcnt;
  logic [SLOT_W-1:0] r_slotcnt;

  // Load aligns the next cycle to slot 1 bit 0; otherwise free-run while enabled.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_bitcnt  <= '0;
      r_slotcnt <= '0;
    end else if (i_load) begin
      r_bitcnt  <= '0;
      r_slotcnt <= SLOT_W'(1);
    end else if (i_en) begin
      if (r_bitcnt == BIT_W'(BITS - 1)) begin
        r_bitcnt  <= '0;
        r_slotcnt <= (r_slotcnt == SLOT_W'(SLOTS - 1)) ? '0 : r_slotcnt + 1'b1;
      end else begin
        r_bitcnt <= r_bitcnt + 1'b1;
      end
    end
  end

  assign o_slotcnt = r_slotcnt;
  assign o_eos_c   = (r_bitcnt == BIT_W'(BITS - 1));
  assign o_eof_c   = o_eos_c && (r_slotcnt == '0);

endmodule

// File: rtl/tdm_sync_recovery_rx.sv
// TDM receiver: recovers frame alignment from the slot-0 FAS and deserializes slots 1-31.
module tdm_sync_recovery_rx
  import tdm_pkg::*;
#(
  parameter logic [BITS-1:0] FAS         = DEFAULT_FAS,
  parameter int unsigned     LOSS_FRAMES = 3
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              sdata,
  input  logic              parity,
  output logic [BITS-1:0]   pdata,
  output logic              pvalid,
  output logic [SLOT_W-1:0] timeslot,
  output logic              check,
  output logic              locked,
  output logic [1:0]        state,
  output logic [7:0]        perr_cnt
);

  localparam int unsigned MISS_W   = (LOSS_FRAMES < 2) ? 1 : $clog2(LOSS_FRAMES);
  localparam logic [7:0]  PERR_MAX = 8'hFF;

  sync_state_t       r_state;
  sync_state_t       w_state_nxt;
  logic [MISS_W-1:0] r_miss_cnt;
  logic [MISS_W-1:0] w_miss_nxt;
  logic [BITS-1:0]   r_sr;
  logic [BITS-1:0]   w_word;
  logic              r_locked;
  logic              r_pvalid;
  slot_rec_t         r_rec;
  slot_rec_t         w_rec;
  logic [7:0]        r_perr_cnt;
  logic [SLOT_W-1:0] w_slotcnt;
  logic              w_eos;
  logic              w_eof;
  logic              w_load;
  logic              w_emit;
  logic              w_cnt_en;
  logic              w_fas_hit;
  logic              w_perr;

  assign w_word    = {r_sr[BITS-2:0], sdata};
  assign w_fas_hit = (w_word == FAS);
  assign w_perr    = (^w_word) ^ parity;
  assign w_cnt_en  = (r_state != HUNT);
  assign w_rec     = {w_word, w_slotcnt, w_perr};

  tdm_slot_counter u_slot_counter (
    .clk       (clk),
    .reset_l   (reset_l),
    .i_load    (w_load),
    .i_en      (w_cnt_en),
    .o_slotcnt (w_slotcnt),
    .o_eos_c   (w_eos),
    .o_eof_c   (w_eof)
  );

  // Hunt/presync/lock decisions; payload is only emitted at slot ends 1-31 in LOCK.
  always_comb begin
    w_state_nxt = r_state;
    w_miss_nxt  = r_miss_cnt;
    w_load      = 1'b0;
    w_emit      = 1'b0;
    unique case (r_state)
      HUNT: begin
        if (w_fas_hit) begin
          w_state_nxt = PRESYNC;
          w_load      = 1'b1;
        end
      end
      PRESYNC: begin
        if (w_eof) begin
          w_state_nxt = w_fas_hit ? LOCK : HUNT;
        end
      end
      LOCK: begin
        if (w_eof) begin
          if (w_fas_hit) begin
            w_miss_nxt = '0;
          end else if (r_miss_cnt == MISS_W'(LOSS_FRAMES - 1)) begin
            w_state_nxt = HUNT;
            w_miss_nxt  = '0;
          end else begin
            w_miss_nxt = r_miss_cnt + 1'b1;
          end
        end else if (w_eos) begin
          w_emit = 1'b1;
        end
      end
      default: begin
        w_state_nxt = HUNT;
        w_miss_nxt  = '0;
      end
    endcase
  end

  // Sync state, miss counter and lock indicator registers.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state    <= HUNT;
      r_miss_cnt <= '0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_miss_cnt <= w_miss_nxt;
      r_locked   <= (w_state_nxt == LOCK);
    end
  end

  // Serial shift register, slot output capture and saturating parity-error count.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_sr       <= '0;
      r_pvalid   <= 1'b0;
      r_rec      <= '0;
      r_perr_cnt <= '0;
    end else begin
      r_sr     <= w_word;
      r_pvalid <= w_emit;
      if (w_emit) begin
        r_rec <= w_rec;
      end
      if (w_emit && w_perr && (r_perr_cnt != PERR_MAX)) begin
        r_perr_cnt <= r_perr_cnt + 1'b1;
      end
    end
  end

  assign pdata    = r_rec.data;
  assign timeslot = r_rec.slot;
  assign check    = r_rec.perr;
  assign pvalid   = r_pvalid;
  assign locked   = r_locked;
  assign state    = r_state;
  assign perr_cnt = r_perr_cnt;

endmodule

// File: tb/tb_tdm_sync_recovery_rx.sv
// Self-checking bench for tdm_sync_recovery_rx: frame-level vector table plus directed corner cases.
module tb_tdm_sync_recovery_rx;
  import tdm_pkg::*;

  logic        clk = 1'b0;
  logic        reset_l;
  logic        sdata;
  logic        parity;
  logic [7:0]  pdata;
  logic        pvalid;
  logic [4:0]  timeslot;
  logic        check;
  logic        locked;
  logic [1:0]  state;
  logic [7:0]  perr_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int pv_cnt  = 0;
  int chk_cnt = 0;
  int chk_slot = 0;
  int exp_ts  = 1;
  int lock_cyc = 0;
  bit first_pending = 1'b1;
  bit prev_locked   = 1'b0;
  logic [7:0] b17;

  typedef struct {
    logic [7:0] fas;
    int flip_slot;
    int exp_state;
    int exp_locked;
    int exp_pv;
    int exp_chk;
    int exp_chk_slot;
    int exp_perr;
    int exp_miss;
  } frame_vec_t;

  frame_vec_t vec [11];

  tdm_sync_recovery_rx dut (
    .clk      (clk),
    .reset_l  (reset_l),
    .sdata    (sdata),
    .parity   (parity),
    .pdata    (pdata),
    .pvalid   (pvalid),
    .timeslot (timeslot),
    .check    (check),
    .locked   (locked),
    .state    (state),
    .perr_cnt (perr_cnt)
  );

  always #5 clk = ~clk;

  // Slot n carries n, except slot 27: 8'h1B would equal the FAS and form a second valid alignment.
  function automatic logic [7:0] payload(input int n);
    if (n == 27) return 8'h9B;
    return 8'(n);
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send_slot(input logic [7:0] b, input logic flip);
    for (int i = 7; i >= 0; i--) begin
      sdata  = b[i];
      parity = (i == 0) ? ((^b) ^ flip) : 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] fas, input int flip_slot, input bit flip_all);
    send_slot(fas, flip_all);
    for (int s = 1; s < 32; s++) send_slot(payload(s), flip_all || (s == flip_slot));
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // Output monitor sampled just after each active edge.
  always @(posedge clk) begin
    #1;
    if (locked && !prev_locked) lock_cyc = cyc;
    if (!locked) begin
      exp_ts = 1;
      first_pending = 1'b1;
    end
    if (pvalid) begin
      pv_cnt++;
      cmp("pvalid_in_lock", int'(locked), 1);
      cmp("timeslot_seq", int'(timeslot), exp_ts);
      cmp("pdata", int'(pdata), int'(payload(exp_ts)));
      if (first_pending) begin
        cmp("first_pvalid_latency", cyc - lock_cyc, 8);
        first_pending = 1'b0;
      end
      if (check) begin
        chk_cnt++;
        chk_slot = int'(timeslot);
      end
      exp_ts = (exp_ts == 31) ? 1 : exp_ts + 1;
    end
    prev_locked = locked;
  end

  // Watchdog against a stalled run.
  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: run exceeded 20000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    //            fas    flip st lk  pv chk cs perr miss
    vec[0]  = '{8'h1B, -1, 1, 0,  0, 0,  0, 0,  -1};
    vec[1]  = '{8'h1B, -1, 2, 1, 31, 0,  0, 0,   0};
    vec[2]  = '{8'h1B, 12, 2, 1, 31, 1, 12, 1,   0};
    vec[3]  = '{8'h00, -1, 2, 1, 31, 0,  0, 1,   1};
    vec[4]  = '{8'h00, -1, 2, 1, 31, 0,  0, 1,   2};
    vec[5]  = '{8'h1B, -1, 2, 1, 31, 0,  0, 1,   0};
    vec[6]  = '{8'h00, -1, 2, 1, 31, 0,  0, 1,   1};
    vec[7]  = '{8'h00, -1, 2, 1, 31, 0,  0, 1,   2};
    vec[8]  = '{8'h00, -1, 0, 0,  0, 0,  0, 1,  -1};
    vec[9]  = '{8'h1B, -1, 1, 0,  0, 0,  0, 1,  -1};
    vec[10] = '{8'h1B, -1, 2, 1, 31, 0,  0, 1,   0};

    reset_l = 1'b0;
    sdata   = 1'b0;
    parity  = 1'b0;
    repeat (3) @(negedge clk);
    cmp("reset_state", int'(state), 0);
    cmp("reset_locked", int'(locked), 0);
    cmp("reset_pvalid", int'(pvalid), 0);
    cmp("reset_pdata", int'(pdata), 0);
    cmp("reset_timeslot", int'(timeslot), 0);
    cmp("reset_check", int'(check), 0);
    cmp("reset_perr_cnt", int'(perr_cnt), 0);
    reset_l = 1'b1;
    send_slot(8'h00, 1'b0);

    // Acquisition, parity error, 2-miss recovery, 3-miss loss and re-acquisition.
    for (int f = 0; f < 11; f++) begin
      pv_cnt = 0; chk_cnt = 0; chk_slot = 0;
      send_frame(vec[f].fas, vec[f].flip_slot, 1'b0);
      cmp($sformatf("F%0d state", f), int'(state), vec[f].exp_state);
      cmp($sformatf("F%0d locked", f), int'(locked), vec[f].exp_locked);
      cmp($sformatf("F%0d pvalid_count", f), pv_cnt, vec[f].exp_pv);
      cmp($sformatf("F%0d check_count", f), chk_cnt, vec[f].exp_chk);
      cmp($sformatf("F%0d perr_cnt", f), int'(perr_cnt), vec[f].exp_perr);
      if (vec[f].exp_chk > 0) cmp($sformatf("F%0d check_slot", f), chk_slot, vec[f].exp_chk_slot);
      if (vec[f].exp_miss >= 0) cmp($sformatf("F%0d miss_cnt", f), int'(dut.r_miss_cnt), vec[f].exp_miss);
    end

    // Asynchronous reset in the middle of slot 17 while locked.
    send_slot(8'h1B, 1'b0);
    for (int s = 1; s < 17; s++) send_slot(payload(s), 1'b0);
    b17 = payload(17);
    for (int i = 7; i >= 4; i--) begin
      sdata = b17[i]; parity = 1'b0;
      @(negedge clk);
    end
    cmp("prerst_locked", int'(locked), 1);
    cmp("prerst_pdata", int'(pdata), 16);
    #2 reset_l = 1'b0;
    #1;
    cmp("arst_state", int'(state), 0);
    cmp("arst_locked", int'(locked), 0);
    cmp("arst_pvalid", int'(pvalid), 0);
    cmp("arst_pdata", int'(pdata), 0);
    cmp("arst_timeslot", int'(timeslot), 0);
    cmp("arst_check", int'(check), 0);
    cmp("arst_perr_cnt", int'(perr_cnt), 0);
    for (int i = 3; i >= 0; i--) begin
      sdata = b17[i]; parity = (i == 0) ? (^b17) : 1'b0;
      @(negedge clk);
    end
    reset_l = 1'b1;
    for (int s = 18; s < 32; s++) send_slot(payload(s), 1'b0);
    cmp("rst_hunt", int'(state), 0);
    pv_cnt = 0;
    send_frame(8'h1B, -1, 1'b0);
    cmp("rst_presync", int'(state), 1);
    cmp("rst_presync_pv", pv_cnt, 0);
    pv_cnt = 0; chk_cnt = 0;
    send_frame(8'h1B, -1, 1'b0);
    cmp("rst_relock", int'(locked), 1);
    cmp("rst_relock_pv", pv_cnt, 31);

    // False FAS in slot 5 while hunting: presync, rejected one frame later, true lock after.
    reset_l = 1'b0;
    repeat (2) @(negedge clk);
    reset_l = 1'b1;
    for (int s = 1; s < 32; s++) begin
      send_slot((s == 5) ? 8'h1B : payload(s), 1'b0);
      if (s == 5) cmp("fm_presync", int'(state), 1);
    end
    for (int s = 0; s < 6; s++) send_slot((s == 0) ? 8'h1B : payload(s), 1'b0);
    cmp("fm_reject", int'(state), 0);
    for (int s = 6; s < 32; s++) send_slot(payload(s), 1'b0);
    cmp("fm_still_hunt", int'(state), 0);
    send_frame(8'h1B, -1, 1'b0);
    cmp("fm_true_presync", int'(state), 1);
    pv_cnt = 0; chk_cnt = 0;
    send_frame(8'h1B, -1, 1'b0);
    cmp("fm_locked", int'(locked), 1);
    cmp("fm_pv", pv_cnt, 31);
    cmp("fm_chk", chk_cnt, 0);

    // Every slot parity flipped (slot 0 included, which must be ignored) to saturate the count.
    for (int f = 1; f <= 10; f++) begin
      pv_cnt = 0; chk_cnt = 0;
      send_frame(8'h1B, -1, 1'b1);
      if (f == 1) begin
        cmp("sat_pv", pv_cnt, 31);
        cmp("sat_chk_slot0_ignored", chk_cnt, 31);
      end
      if (f == 8) cmp("sat_perr_248", int'(perr_cnt), 248);
      if (f == 9) cmp("sat_perr_9", int'(perr_cnt), 255);
    end
    cmp("sat_perr_hold", int'(perr_cnt), 255);
    cmp("sat_locked", int'(locked), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_sync_recovery_rx.md
# tdm_sync_recovery_rx

Receive end of the 32-slot TDM serial channel for links that carry no separate frame-sync wire. It recovers frame alignment from a frame alignment word (FAS) sent in timeslot 0 using a hunt / pre-sync / lock state machine. It then deserializes timeslots 1–31 into bytes, checks the per-slot even-parity bit, and reports slot number, parity errors and lock status to downstream logic.

## Interface
- `FAS`, 8'h1B: frame alignment word carried in slot 0, MSB first.
- `LOSS_FRAMES`, 3: number of consecutive bad FAS frames in LOCK that force a return to HUNT.
- `clk` input 1: bit clock; one serial bit per rising edge.
- `reset_l` input 1: reset, asynchronous assert, active-low.
- `sdata` input 1: serial data, MSB of each slot first.
- `parity` input 1: even-parity bit for the current slot, valid in the same cycle as the slot's bit 0 (LSB).
- `pdata` output 8: last received byte of slots 1–31.
- `pvalid` output 1: one-cycle strobe; `pdata`, `timeslot` and `check` are valid.
- `timeslot` output 5: slot number of `pdata` (1–31).
- `check` output 1: high when the slot's parity mismatched; qualified by `pvalid`.
- `locked` output 1: high in LOCK.
- `state` output 2: 0 = HUNT, 1 = PRESYNC, 2 = LOCK.
- `perr_cnt` output 8: saturating count of parity errors seen in LOCK.

## Operation
- Frame: 32 slots × 8 bits = 256 clocks. Slot 0 carries `FAS`. Slots 1–31 carry payload.
- Shift register `sr[7:0]` shifts in `sdata` every cycle. `word = {sr[6:0], sdata}` is the byte ending in the current cycle.
- Counters: `bitcnt[2:0]` and `slotcnt[4:0]` free-run while aligned. The end of a slot is `bitcnt == 7`.
- HUNT:
  - Compare `word` to `FAS` every cycle.
  - On a match, go to PRESYNC. Load `bitcnt = 0` and `slotcnt = 1` for the next cycle.
- PRESYNC:
  - At the next slot-0 end (256 clocks after the match), check `word == FAS`.
  - On a match, go to LOCK. On a mismatch, go to HUNT.
  - No `pvalid` is issued.
- LOCK:
  - At each slot-0 end, a `FAS` mismatch increments `miss_cnt`. A match clears it.
  - When `miss_cnt` reaches `LOSS_FRAMES`, go to HUNT.
  - At each end of slots 1–31, output `pdata <= word`, `timeslot <= slotcnt`, `check <= ^word ^ parity`, and pulse `pvalid`.
- `perr_cnt` increments on `check = 1` while in LOCK. It saturates at 255 and clears only on reset.
- Slot 0 parity is ignored.
- Wrap-around: `slotcnt` goes from 31 to 0; `bitcnt` goes from 7 to 0.
- Simultaneous events: when a loss of lock occurs at a slot-0 end, HUNT begins the next cycle. The same cycle's `word` is not re-used as a hunt candidate.

## Timing
- Reset values: `pdata = 0`, `pvalid = 0`, `timeslot = 0`, `check = 0`, `locked = 0`, `state = HUNT`, `perr_cnt = 0`, `sr = 0`, `bitcnt = 0`, `slotcnt = 0`, `miss_cnt = 0`.
- Latency: `pvalid` rises one clock after the edge that sampled a slot's LSB. It lasts one cycle, once every 8 clocks in LOCK, 31 times per frame.
- `locked` rises one clock after the edge that sampled the confirming `FAS` LSB.
- Lock acquisition takes at least 2 frames (2 × 256 clocks) of clean FAS.
- `pvalid` never asserts outside LOCK. The first `pvalid` after lock is for slot 1, 8 clocks after `locked` rises.
- Reset asserted mid-frame clears all state asynchronously. After release, the block re-hunts from HUNT.
- A false FAS match inside payload is rejected by PRESYNC and costs one frame.

## Structure
- Shared package `tdm_pkg`:
  - `SLOTS = 32`, `SLOT_W = 5`, `BITS = 8`, default `FAS`.
  - Enum `sync_state_t {HUNT, PRESYNC, LOCK}`.
  - This package is also used by the transmitter-side FAS inserter.
- One sub-module, `tdm_slot_counter`: loadable `bitcnt`/`slotcnt` with end-of-slot and end-of-frame flags.
- The state machine, shift register, parity check and counters stay in the top.

## Test plan
- Clean acquisition: drive frames with FAS = 8'h1B, slot n = n, correct parity. Required response:
  - `locked` after the 2nd FAS.
  - Then `pvalid` for `timeslot` = 1..31 with `pdata` = 1..31.
  - `check = 0` and `perr_cnt = 0`.
- False match: inject 8'h1B in slot 5 of the first frame while hunting. Required response: PRESYNC is entered, then HUNT one frame later, and lock is achieved on the true alignment.
- Parity error: in LOCK, flip the `parity` bit for slot 12. Required response:
  - `check = 1` on `timeslot` 12 only.
  - `perr_cnt` = 1.
- Loss of lock: corrupt FAS in 2 consecutive frames, then 3 consecutive frames. Required response:
  - After 2 bad frames, the block stays in LOCK (`miss_cnt` = 2), and the next good FAS clears `miss_cnt`.
  - After 3 bad frames, `state` = HUNT and `pvalid` stops.
- Reset mid-frame: assert `reset_l = 0` during slot 17 in LOCK. Required response:
  - All outputs return to their reset values immediately, without waiting for a clock edge.
  - The block re-locks 2 frames after release.
- Saturation: force 300 parity errors. Required response: `perr_cnt` holds at 255.
